// File: rtl/ahb_sram_pkg.sv
// Shared AHB-lite constants, bridge FSM encoding and latched transfer attributes.
package ahb_sram_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [2:0] {
    IDLE, WR, RD, RD_DEFER, RMW_RD, RMW_WR, ERR1, ERR2
  } state_t;

  typedef struct packed {
    logic [2:0] size;
    logic [1:0] lane;
  } xfer_t;
endpackage

// File: rtl/ahb_sram_bemerge.sv
// Byte-lane merge for read-modify-write; only built with AHB_SRAM_BRIDGE_RMW_EN.
module ahb_sram_bemerge
  import ahb_sram_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [2:0]  hsize,
  input  logic [1:0]  addr,
  output logic [31:0] merged
);
  logic [NUM_LANES-1:0]             sel;
  logic [NUM_LANES-1:0][LANE_W-1:0] old_l, new_l, mrg_l;

  assign old_l = old_word;
  assign new_l = new_word;

  always_comb begin
    sel = '0;
    case (hsize)
      HSIZE_BYTE: sel[addr] = 1'b1;
      HSIZE_HALF: sel = addr[1] ? 4'b1100 : 4'b0011;
      default:    sel = '1;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mrg_l[i] = sel[i] ? new_l[i] : old_l[i];
  end

  assign merged = mrg_l;
endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-lite subordinate to single-port SRAM bridge. Define AHB_SRAM_BRIDGE_RMW_EN to
// support sub-word writes by read-modify-write; otherwise they get an ERROR response.
module ahb_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  sram_cs,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data,
  input  logic [31:0]           sram_q
);
  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  xfer_t                 xfer_q;
  logic                  can_acc, accept, acc_rd, acc_wr, wr_word, sram_busy;
  logic [31:0]           rmw_data;
  logic                  unused_ok;

`ifdef AHB_SRAM_BRIDGE_RMW_EN
  localparam state_t SUBWR_ST = RMW_RD;
  ahb_sram_bemerge u_bemerge (
    .old_word (sram_q),
    .new_word (hwdata),
    .hsize    (xfer_q.size),
    .addr     (xfer_q.lane),
    .merged   (rmw_data)
  );
`else
  localparam state_t SUBWR_ST = ERR1;
  assign rmw_data = hwdata;
`endif

  // Wait-state cycles never overlap a new address phase.
  assign can_acc   = state inside {IDLE, WR, RD, RMW_WR, ERR2};
  assign accept    = hsel & htrans[1] & hready & can_acc;
  assign acc_rd    = accept & ~hwrite;
  assign acc_wr    = accept & hwrite;
  assign wr_word   = hsize == HSIZE_WORD;
  assign sram_busy = state inside {WR, RMW_WR};
  assign unused_ok = ^{haddr[31:ADDR_WIDTH+2], htrans[0], xfer_q};

  always_comb begin
    state_n = IDLE;
    case (state)
      RD_DEFER: state_n = RD;
      RMW_RD:   state_n = RMW_WR;
      ERR1:     state_n = ERR2;
      default: begin
        if (acc_rd)      state_n = sram_busy ? RD_DEFER : RD;
        else if (acc_wr) state_n = wr_word ? WR : SUBWR_ST;
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    sram_cs   = 1'b0;
    sram_wen  = 1'b1;
    sram_addr = addr_q;
    sram_data = '0;
    case (state)
      WR:       begin sram_cs = 1'b1; sram_wen = 1'b0; sram_data = hwdata; end
      RD:       hrdata = sram_q;
      RD_DEFER: begin hreadyout = 1'b0; sram_cs = 1'b1; end
      RMW_RD:   begin hreadyout = 1'b0; sram_cs = 1'b1; end
      RMW_WR:   begin sram_cs = 1'b1; sram_wen = 1'b0; sram_data = rmw_data; end
      ERR1:     begin hresp = 1'b1; hreadyout = 1'b0; end
      ERR2:     hresp = 1'b1;
      default:  ;
    endcase
    // A read strobes straight from the address phase when the SRAM is free.
    if (acc_rd && !sram_busy) begin
      sram_cs   = 1'b1;
      sram_wen  = 1'b1;
      sram_addr = haddr[ADDR_WIDTH+1:2];
    end
    // Reset kills any in-flight write in the same cycle.
    if (rst) begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      hrdata    = '0;
      sram_cs   = 1'b0;
      sram_wen  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      xfer_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q      <= haddr[ADDR_WIDTH+1:2];
        xfer_q.size <= hsize;
        xfer_q.lane <= haddr[1:0];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Randomized bench for ahb_sram_bridge against a transaction-level memory model.
module tb_ahb_sram_bridge;
  localparam int AW = 8;
`ifdef AHB_SRAM_BRIDGE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0]   haddr, hwdata, hrdata;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          sram_cs, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_data, sram_q;
  int            checks = 0, errors = 0;
  bit            abort = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_sram_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .sram_cs(sram_cs), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_data(sram_data), .sram_q(sram_q)
  );

  // SRAM device: registered read data, write on strobe with wen low.
  bit [31:0] sram [2**AW];
  always @(posedge clk) begin
    if (sram_cs && !sram_wen) sram[sram_addr] <= sram_data;
    if (sram_cs && sram_wen)  sram_q <= sram[sram_addr];
  end

  bit [31:0] ref_mem [2**AW];

  typedef struct { bit act; bit wr; bit [2:0] sz; bit [31:0] a; bit [31:0] d; } txn_t;
  txn_t tq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit act, input bit wr, input bit [2:0] sz,
                              input bit [31:0] a, input bit [31:0] d);
    txn_t t;
    t.act = act; t.wr = wr; t.sz = sz; t.a = a; t.d = d;
    return t;
  endfunction

  function automatic logic [AW-1:0] widx(input bit [31:0] a);
    return a[AW+1:2];
  endfunction

  function automatic bit subwr(input txn_t t);
    return t.act && t.wr && t.sz != 3'd2;
  endfunction

  function automatic bit writes_sram(input txn_t t);
    return t.act && t.wr && (t.sz == 3'd2 || RMW);
  endfunction

  // Replace the (1<<sz) bytes of the naturally aligned container holding address a.
  function automatic bit [31:0] merge_ref(input bit [31:0] o, input bit [31:0] n,
                                          input bit [2:0] sz, input bit [1:0] a);
    bit [31:0] r;
    int nb, base;
    r = o; nb = 1 << sz; base = (int'(a) / nb) * nb;
    for (int b = 0; b < 4; b++)
      if (b >= base && b < base + nb) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic drive_ap(input txn_t t);
    hsel   = t.act ? 1'b1 : t.a[4];
    htrans = t.act ? {1'b1, t.d[31]} : {1'b0, t.a[5]};
    hwrite = t.wr;
    hsize  = t.sz;
    haddr  = t.a;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    int r;
    r = $urandom_range(0, 99);
    t.act = r >= 15;
    t.wr  = r >= 55;
    t.a   = $urandom & 32'h0000_0c3c;
    t.d   = $urandom;
    if (!t.wr || r >= 85) t.sz = t.wr ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 2));
    else                  t.sz = 3'd2;
    if (t.sz == 3'd0)      t.a[1:0] = 2'($urandom_range(0, 3));
    else if (t.sz == 3'd1) t.a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
    return t;
  endfunction

  // Plays the queue as a pipelined AHB master; entered and left at posedge+1.
  task automatic run_queue();
    txn_t ap, dp;
    bit ap_v, dp_v, rdy, busy, exp_err;
    int k, exp_w;
    logic [31:0] exp_d;
    dp = mk(0, 0, 2, 0, 0); dp_v = 0; k = 0; exp_w = 0; exp_err = 0;
    ap_v = tq.size() > 0;
    ap = ap_v ? tq.pop_front() : mk(0, 0, 2, 0, 0);
    drive_ap(ap);
    while (ap_v || dp_v) begin
      @(negedge clk);
      rdy = hreadyout;
      if (dp_v) begin
        chk("hreadyout", {31'd0, hreadyout}, {31'd0, k >= exp_w});
        chk("hresp", {31'd0, hresp}, {31'd0, exp_err});
        if (!writes_sram(dp)) chk("sram_wen_idle", {31'd0, sram_wen}, 32'd1);
        if (rdy) begin
          if (dp.act && !dp.wr) chk("hrdata", hrdata, ref_mem[widx(dp.a)]);
          else                  chk("hrdata_zero", hrdata, 32'd0);
          if (writes_sram(dp)) begin
            exp_d = (dp.sz == 3'd2) ? dp.d : merge_ref(ref_mem[widx(dp.a)], dp.d, dp.sz, dp.a[1:0]);
            chk("sram_cs", {31'd0, sram_cs}, 32'd1);
            chk("sram_wen", {31'd0, sram_wen}, 32'd0);
            chk("sram_addr", {24'd0, sram_addr}, {24'd0, widx(dp.a)});
            chk("sram_data", sram_data, exp_d);
            ref_mem[widx(dp.a)] = exp_d;
          end
        end
      end
      if (!rdy) begin
        k++;
        if (k > 4) begin
          checks++; errors++;
          $display("FAIL wait_timeout hreadyout low for %0d cycles, expected at most %0d", k, exp_w);
          abort = 1;
          return;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        busy    = dp_v && writes_sram(dp);
        dp      = ap; dp_v = ap_v; k = 0;
        exp_w   = ((dp.act && !dp.wr && busy) || subwr(dp)) ? 1 : 0;
        exp_err = subwr(dp) && !RMW;
        hwdata  = dp.d;
        ap_v    = tq.size() > 0;
        ap      = ap_v ? tq.pop_front() : mk(0, 0, 2, 0, 0);
        drive_ap(ap);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hwdata = '0;
    drive_ap(mk(0, 0, 2, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_sram_cs", {31'd0, sram_cs}, 32'd0);
    chk("rst_sram_wen", {31'd0, sram_wen}, 32'd1);
    chk("rst_hrdata", hrdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // write then read-back of same word; preload + streaming reads; sub-word write; aliasing
    tq.push_back(mk(1, 1, 2, 32'h10, 32'hDEADBEEF));
    tq.push_back(mk(1, 0, 2, 32'h10, 0));
    tq.push_back(mk(0, 0, 2, 0, 0));
    for (int i = 0; i < 4; i++) tq.push_back(mk(1, 1, 2, 32'(i * 4), 32'(i + 1)));
    tq.push_back(mk(0, 0, 2, 0, 0));
    for (int i = 0; i < 4; i++) tq.push_back(mk(1, 0, 2, 32'(i * 4), 0));
    tq.push_back(mk(1, 1, 2, 32'h20, 32'h11223344));
    tq.push_back(mk(1, 1, 0, 32'h22, 32'h00AA0000));
    tq.push_back(mk(0, 0, 2, 0, 0));
    tq.push_back(mk(1, 0, 2, 32'h20, 0));
    tq.push_back(mk(1, 1, 2, 32'h400, 32'hCAFE0001));
    tq.push_back(mk(1, 0, 2, 32'h0, 0));
    tq.push_back(mk(1, 1, 2, 32'h30, 32'h5555AAAA));
    run_queue();

    if (!abort) begin
      // reset lands on the write data phase: nothing may reach the SRAM
      drive_ap(mk(1, 1, 2, 32'h30, 0));
      @(posedge clk); #1;
      hwdata = 32'hBAD0BAD0; drive_ap(mk(0, 0, 2, 0, 0)); rst = 1'b1;
      @(negedge clk);
      chk("rstwr_sram_wen", {31'd0, sram_wen}, 32'd1);
      chk("rstwr_sram_cs", {31'd0, sram_cs}, 32'd0);
      chk("rstwr_hreadyout", {31'd0, hreadyout}, 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("postrst_hreadyout", {31'd0, hreadyout}, 32'd1);
      chk("postrst_hresp", {31'd0, hresp}, 32'd0);
      chk("postrst_mem", sram[12], ref_mem[12]);
      @(posedge clk); #1;
      tq.push_back(mk(1, 0, 2, 32'h30, 0));
      run_queue();
    end

    if (!abort) begin
      for (int i = 0; i < 300; i++) tq.push_back(rnd_txn());
      run_queue();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
